// File: rtl/instruction_fetch_controller_pkg.sv
// Shared fetch-controller definitions: FSM state encoding, instruction width and PC helpers.
package instruction_fetch_controller_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'h0,
    FETCH = 2'h1,
    DRAIN = 2'h2
  } fetchState_e;

  localparam int          INST_WIDTH   = 32;
  localparam logic [31:0] PC_INCREMENT = 32'd4;

  function automatic logic [31:0] nextPc(input logic [31:0] pc);
    return pc + PC_INCREMENT;
  endfunction

  function automatic logic [31:0] satInc(input logic [31:0] value);
    return (value == 32'hFFFF_FFFF) ? value : value + 32'd1;
  endfunction

endpackage

// File: rtl/instruction_fetch_outstanding_counter.sv
// Up/down count of un-returned fetch requests with limit compare and underflow guard.
module instruction_fetch_outstanding_counter #(
  parameter int unsigned LIMIT = 4
) (
  input  logic       iCLOCK,
  input  logic       iRESET_SYNC,
  input  logic       inc,
  input  logic       dec,
  output logic [2:0] count,
  output logic       belowLimit,
  output logic       isZero
);

  localparam logic [2:0] LIMIT_W = 3'(LIMIT);

  logic [2:0] count_r;
  logic       decEff_s;

  // A response with nothing in flight is spurious and must not wrap the count
  always_comb begin
    decEff_s = dec && (count_r != 3'd0);
  end

  // Counter register; simultaneous inc and dec cancel
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      count_r <= 3'd0;
    end else if (inc && !decEff_s) begin
      count_r <= count_r + 3'd1;
    end else if (!inc && decEff_s) begin
      count_r <= count_r - 3'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign count      = count_r;
  assign belowLimit = (count_r < LIMIT_W);
  assign isZero     = (count_r == 3'd0);

endmodule

// File: rtl/instruction_fetch_controller.sv
// Instruction fetch sequencer: issues sequential fetches, forwards in-order responses, flushes on redirect.
// Optional perf counters (oPERF_DISCARD, oPERF_STALL) under MIST1032ISA_IFETCH_PERF_COUNTER_EN.
module instruction_fetch_controller
  import instruction_fetch_controller_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR    = 32'h0000_0000,
  parameter int unsigned OUTSTANDING_MAX = 4
) (
  input  logic                  iCLOCK,
  input  logic                  iRESET_SYNC,
  input  logic                  iBRANCH_VALID,
  input  logic [31:0]           iBRANCH_ADDR,
  output logic                  oMEM_REQ,
  output logic [31:0]           oMEM_ADDR,
  input  logic                  iMEM_LOCK,
  input  logic                  iMEM_VALID,
  input  logic [INST_WIDTH-1:0] iMEM_DATA,
  output logic                  oBUF_INST_VALID,
  output logic [INST_WIDTH-1:0] oBUF_INST,
  output logic [31:0]           oBUF_PC,
  output logic                  oBUF_REFRESH,
  input  logic                  iBUF_FETCH_STOP,
  input  logic                  iBUF_LOCK,
  output logic                  oOVERFLOW
`ifdef MIST1032ISA_IFETCH_PERF_COUNTER_EN
  ,
  output logic [31:0]           oPERF_DISCARD,
  output logic [31:0]           oPERF_STALL
`endif
);

  fetchState_e           state_r, nextState_s;
  logic [31:0]           reqPc_r, rspPc_r, bufPc_r;
  logic [INST_WIDTH-1:0] bufInst_r;
  logic                  bufValid_r, refresh_r, overflow_r;
  logic [2:0]            outstanding_s, remaining_s;
  logic                  belowLimit_s, zero_s;
  logic                  issue_s, accept_s, rspValid_s, redirect_s, forward_s;

  assign redirect_s  = iBRANCH_VALID && ((state_r == FETCH) || (state_r == DRAIN));
  assign issue_s     = !iRESET_SYNC && (state_r == FETCH) && !iBRANCH_VALID
                       && !iBUF_FETCH_STOP && belowLimit_s;
  assign accept_s    = issue_s && !iMEM_LOCK;
  assign rspValid_s  = iMEM_VALID && !zero_s;
  assign forward_s   = rspValid_s && (state_r == FETCH) && !redirect_s;
  // Requests still owed after this cycle; these are the stale ones once a redirect is taken
  assign remaining_s = outstanding_s - {2'b00, rspValid_s} + {2'b00, accept_s};

  instruction_fetch_outstanding_counter #(
    .LIMIT(OUTSTANDING_MAX)
  ) uOutstanding (
    .iCLOCK     (iCLOCK),
    .iRESET_SYNC(iRESET_SYNC),
    .inc        (accept_s),
    .dec        (iMEM_VALID),
    .count      (outstanding_s),
    .belowLimit (belowLimit_s),
    .isZero     (zero_s)
  );

  // FSM state register
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      state_r <= BOOT;
    end else begin
      state_r <= nextState_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    nextState_s = state_r;
    case (state_r)
      BOOT: nextState_s = FETCH;
      FETCH: begin
        if (redirect_s && (remaining_s != 3'd0)) begin
          nextState_s = DRAIN;
        end else begin
          nextState_s = FETCH;
        end
      end
      DRAIN: begin
        if (remaining_s == 3'd0) begin
          nextState_s = FETCH;
        end else begin
          nextState_s = DRAIN;
        end
      end
      default: nextState_s = BOOT;
    endcase
  end

  // FSM outputs toward the memory port
  always_comb begin
    oMEM_REQ = issue_s;
    if (iRESET_SYNC) begin
      oMEM_ADDR = 32'h0000_0000;
    end else begin
      oMEM_ADDR = reqPc_r;
    end
  end

  // PC tracking and registered buffer-side outputs
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      reqPc_r    <= RESET_VECTOR;
      rspPc_r    <= RESET_VECTOR;
      bufValid_r <= 1'b0;
      bufInst_r  <= '0;
      bufPc_r    <= 32'h0000_0000;
      refresh_r  <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      refresh_r  <= redirect_s;
      bufValid_r <= forward_s;
      if (forward_s) begin
        bufInst_r <= iMEM_DATA;
        bufPc_r   <= rspPc_r;
      end
      if (redirect_s) begin
        reqPc_r <= iBRANCH_ADDR;
        rspPc_r <= iBRANCH_ADDR;
      end else begin
        if (accept_s) reqPc_r <= nextPc(reqPc_r);
        if (forward_s) rspPc_r <= nextPc(rspPc_r);
      end
      if (forward_s && iBUF_LOCK) overflow_r <= 1'b1;
    end
  end

  assign oBUF_INST_VALID = bufValid_r;
  assign oBUF_INST       = bufInst_r;
  assign oBUF_PC         = bufPc_r;
  assign oBUF_REFRESH    = refresh_r;
  assign oOVERFLOW       = overflow_r;

`ifdef MIST1032ISA_IFETCH_PERF_COUNTER_EN
  logic [31:0] perfDiscard_r, perfStall_r;

  // Saturating counts of dropped responses and non-issuing FETCH cycles
  always_ff @(posedge iCLOCK) begin
    if (iRESET_SYNC) begin
      perfDiscard_r <= 32'h0000_0000;
      perfStall_r   <= 32'h0000_0000;
    end else begin
      if (rspValid_s && !forward_s) perfDiscard_r <= satInc(perfDiscard_r);
      if ((state_r == FETCH) && (!issue_s || iMEM_LOCK)) perfStall_r <= satInc(perfStall_r);
    end
  end

  assign oPERF_DISCARD = perfDiscard_r;
  assign oPERF_STALL   = perfStall_r;
`endif

endmodule

// File: tb/tb_instruction_fetch_controller.sv
// Randomized scoreboard bench: a request-queue memory/reference model predicts issue and forwarded words.
module tb_instruction_fetch_controller;

  localparam logic [31:0] RV   = 32'h0000_0100;
  localparam int          OMAX = 4;

  logic        iCLOCK = 1'b0;
  logic        iRESET_SYNC = 1'b1;
  logic        iBRANCH_VALID = 1'b0;
  logic [31:0] iBRANCH_ADDR = 32'h0;
  logic        oMEM_REQ;
  logic [31:0] oMEM_ADDR;
  logic        iMEM_LOCK = 1'b0;
  logic        iMEM_VALID = 1'b0;
  logic [31:0] iMEM_DATA = 32'h0;
  logic        oBUF_INST_VALID;
  logic [31:0] oBUF_INST;
  logic [31:0] oBUF_PC;
  logic        oBUF_REFRESH;
  logic        iBUF_FETCH_STOP = 1'b0;
  logic        iBUF_LOCK = 1'b0;
  logic        oOVERFLOW;
`ifdef MIST1032ISA_IFETCH_PERF_COUNTER_EN
  logic [31:0] oPERF_DISCARD;
  logic [31:0] oPERF_STALL;
`endif

  always #5 iCLOCK = ~iCLOCK;

  instruction_fetch_controller #(
    .RESET_VECTOR   (RV),
    .OUTSTANDING_MAX(OMAX)
  ) dut (
    .iCLOCK         (iCLOCK),
    .iRESET_SYNC    (iRESET_SYNC),
    .iBRANCH_VALID  (iBRANCH_VALID),
    .iBRANCH_ADDR   (iBRANCH_ADDR),
    .oMEM_REQ       (oMEM_REQ),
    .oMEM_ADDR      (oMEM_ADDR),
    .iMEM_LOCK      (iMEM_LOCK),
    .iMEM_VALID     (iMEM_VALID),
    .iMEM_DATA      (iMEM_DATA),
    .oBUF_INST_VALID(oBUF_INST_VALID),
    .oBUF_INST      (oBUF_INST),
    .oBUF_PC        (oBUF_PC),
    .oBUF_REFRESH   (oBUF_REFRESH),
    .iBUF_FETCH_STOP(iBUF_FETCH_STOP),
    .iBUF_LOCK      (iBUF_LOCK),
`ifdef MIST1032ISA_IFETCH_PERF_COUNTER_EN
    .oPERF_DISCARD  (oPERF_DISCARD),
    .oPERF_STALL    (oPERF_STALL),
`endif
    .oOVERFLOW      (oOVERFLOW)
  );

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          ready;
  } flight_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } fwd_t;

  flight_t     flightQ[$];
  fwd_t        expQ[$];
  int          checks = 0;
  int          errors = 0;
  bit          expRefresh = 1'b0;
  bit          expOverflow = 1'b0;
  bit          expReset = 1'b1;
  int unsigned expDiscard = 0;
  int unsigned expStall = 0;
  logic [31:0] nextAddr = RV;
  bit          booting = 1'b1;
  int          cycle = 0;
  int          lastReady = 0;
  int          pBranch = 0, pLock = 0, pStop = 0, pValid = 0, pBufLock = 0;
  int          latMin = 2, latMax = 2;

  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[15:0], 16'h0000} ^ {16'h0000, ~a[17:2]} ^ 32'h5A3C_0000;
  endfunction

  function automatic int staleCount();
    int n = 0;
    foreach (flightQ[i]) if (flightQ[i].stale) n++;
    return n;
  endfunction

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  // One stimulus cycle: drive at negedge, then predict what the next rising edge must do
  task automatic stepCycle(input bit rst);
    bit          br, stop, lock, bl, valid, fetching, expReq, accept;
    logic [31:0] tgt;
    flight_t     e, n;
    fwd_t        f;
    int          lat;
    @(negedge iCLOCK);
    cycle++;
    br    = !rst && !booting && ($urandom_range(99) < pBranch);
    tgt   = ($urandom_range(9) == 0) ? 32'hFFFF_FFF4 : ($urandom & 32'hFFFF_FFFC);
    stop  = $urandom_range(99) < pStop;
    lock  = $urandom_range(99) < pLock;
    bl    = $urandom_range(99) < pBufLock;
    valid = !rst && (flightQ.size() > 0) && (flightQ[0].ready <= cycle)
            && ($urandom_range(99) < pValid);
    iRESET_SYNC     = rst;
    iBRANCH_VALID   = br;
    iBRANCH_ADDR    = tgt;
    iBUF_FETCH_STOP = stop;
    iMEM_LOCK       = lock;
    iBUF_LOCK       = bl;
    iMEM_VALID      = valid;
    iMEM_DATA       = valid ? memWord(flightQ[0].addr) : $urandom;
    #1;
    if (rst) begin
      check1("mem_req_reset", oMEM_REQ, 1'b0);
      check32("mem_addr_reset", oMEM_ADDR, 32'h0);
      flightQ.delete();
      nextAddr    = RV;
      booting     = 1'b1;
      expRefresh  = 1'b0;
      expOverflow = 1'b0;
      expDiscard  = 0;
      expStall    = 0;
      expReset    = 1'b1;
      lastReady   = 0;
      return;
    end
    expReset = 1'b0;
    // No new fetch while booting, while stale responses are owed, or when gated
    fetching = !booting && (staleCount() == 0);
    expReq   = fetching && !br && !stop && (flightQ.size() < OMAX);
    check1("mem_req", oMEM_REQ, expReq);
    accept = expReq && !lock;
    if (accept) check32("mem_addr", oMEM_ADDR, nextAddr);
    if (fetching && (!expReq || lock)) expStall++;
    if (valid) begin
      e = flightQ.pop_front();
      if (!e.stale && !br) begin
        f.pc   = e.addr;
        f.inst = memWord(e.addr);
        expQ.push_back(f);
        if (bl) expOverflow = 1'b1;
      end else begin
        expDiscard++;
      end
    end
    expRefresh = br;
    if (br) begin
      foreach (flightQ[i]) flightQ[i].stale = 1'b1;
      nextAddr = tgt;
    end
    if (accept) begin
      lat = cycle + int'($urandom_range(latMax, latMin));
      if (lat < lastReady) lat = lastReady;
      lastReady = lat;
      n.addr  = nextAddr;
      n.stale = 1'b0;
      n.ready = lat;
      flightQ.push_back(n);
      nextAddr = nextAddr + 32'd4;
    end
    booting = 1'b0;
  endtask

  task automatic runPhase(input int cycles, input int b, input int l, input int s,
                          input int v, input int bl, input int lmin, input int lmax);
    pBranch = b; pLock = l; pStop = s; pValid = v; pBufLock = bl;
    latMin = lmin; latMax = lmax;
    for (int i = 0; i < cycles; i++) stepCycle(1'b0);
  endtask

  // Monitor: compares registered buffer-side outputs against the scoreboard after each edge
  initial begin : monitor
    fwd_t f;
    forever begin
      @(posedge iCLOCK);
      #1;
      check1("refresh", oBUF_REFRESH, expRefresh);
      check1("overflow", oOVERFLOW, expOverflow);
      if (expQ.size() > 0) begin
        f = expQ.pop_front();
        check1("buf_valid", oBUF_INST_VALID, 1'b1);
        check32("buf_pc", oBUF_PC, f.pc);
        check32("buf_inst", oBUF_INST, f.inst);
      end else begin
        check1("buf_valid", oBUF_INST_VALID, 1'b0);
      end
      if (expReset) begin
        check32("buf_pc_reset", oBUF_PC, 32'h0);
        check32("buf_inst_reset", oBUF_INST, 32'h0);
      end
`ifdef MIST1032ISA_IFETCH_PERF_COUNTER_EN
      check32("perf_discard", oPERF_DISCARD, expDiscard);
      check32("perf_stall", oPERF_STALL, expStall);
`endif
    end
  end

  initial begin : stimulus
    int guard;
    stepCycle(1'b1);
    stepCycle(1'b1);
    // Burst of OMAX requests with memory held off, then latency-2 responses
    runPhase(8, 0, 0, 0, 0, 0, 2, 2);
    runPhase(20, 0, 0, 0, 100, 0, 2, 2);
    // Frequent redirects with several requests in flight
    runPhase(300, 8, 0, 0, 60, 0, 2, 4);
    // Fetch-stop window with requests in flight, then resume
    runPhase(10, 0, 0, 100, 100, 0, 2, 3);
    runPhase(20, 0, 0, 0, 100, 0, 1, 3);
    // Memory locked
    runPhase(6, 0, 100, 0, 100, 0, 1, 2);
    runPhase(2500, 4, 20, 10, 70, 3, 1, 5);
    // Reset in the middle of traffic clears overflow and abandons in-flight requests
    stepCycle(1'b1);
    stepCycle(1'b1);
    runPhase(1500, 5, 25, 15, 65, 10, 1, 6);
    // Quiesce: no issue, answer everything still owed
    pBranch = 0; pLock = 0; pStop = 100; pValid = 100; pBufLock = 0;
    guard = 0;
    while ((flightQ.size() > 0) && (guard < 300)) begin
      stepCycle(1'b0);
      guard++;
    end
    checks++;
    if (flightQ.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: %0d requests still owed, required 0", flightQ.size());
    end
    @(posedge iCLOCK);
    #2;
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("FAIL forward_pending: %0d expected words unseen, required 0", expQ.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
